// File: rtl/mac_result_collector.sv
// Drain side of MAC_FP: tracks issued ops through the fixed latency, packs results
// (FP16 two per word) into a valid/ready FIFO, and grants issue credit against FIFO space.
module mac_result_collector #(
  parameter int LAT   = 2,
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        issue_i,
  input  logic [1:0]  mode_i,
  input  logic        last_i,
  input  logic [31:0] res_i,
  input  logic        nv_i,
  input  logic        of_i,
  input  logic        uf_i,
  input  logic        nx_i,
  output logic        issue_ok_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] out_data_o,
  output logic        out_last_o,
  output logic [3:0]  fflags_o,
  input  logic        fflags_clr_i,
  output logic        overflow_o,
  output logic        mode_err_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(DEPTH + LAT + 1) + 1;

  logic [LAT:1]            pipe_vld_q;
  logic [LAT:1][1:0]       pipe_mode_q;
  logic [LAT:1]            pipe_last_q;
  logic [DEPTH-1:0][31:0]  mem_q;
  logic [DEPTH-1:0]        mem_last_q;
  logic [AW-1:0]           wr_q, rd_q;
  logic [CW-1:0]           cnt_q;
  logic                    pend_vld_q, pend_vld_d;
  logic [15:0]             pend_q, pend_d;
  logic                    tile_act_q;
  logic [1:0]              tile_mode_q;
  logic [3:0]              fflags_q;
  logic                    ovf_q, merr_q;

  logic        cap, cap_last, mode_bad, push, pop, full, push_ok;
  logic [1:0]  cap_raw, cap_eff, cur_mode;
  logic [31:0] push_data;
  logic [3:0]  cap_flags;
  logic [TW-1:0] inflight;

  assign cap       = pipe_vld_q[LAT];
  assign cap_last  = pipe_last_q[LAT];
  assign cap_raw   = pipe_mode_q[LAT];
  assign cap_eff   = (cap_raw == 2'b11) ? 2'b10 : cap_raw;
  assign cur_mode  = tile_act_q ? tile_mode_q : cap_eff;
  assign mode_bad  = cap && ((cap_raw == 2'b11) || (tile_act_q && cap_eff != tile_mode_q));
  assign cap_flags = {nv_i, of_i, uf_i, nx_i};

  // FP16 tiles hold the first half until its partner (or the tile end) arrives
  always_comb begin
    push       = 1'b0;
    push_data  = res_i;
    pend_vld_d = pend_vld_q;
    pend_d     = pend_q;
    if (cap) begin
      if (cur_mode == 2'b00) begin
        if (pend_vld_q) begin
          push       = 1'b1;
          push_data  = {res_i[15:0], pend_q};
          pend_vld_d = 1'b0;
        end else if (cap_last) begin
          push       = 1'b1;
          push_data  = {16'h0, res_i[15:0]};
        end else begin
          pend_vld_d = 1'b1;
          pend_d     = res_i[15:0];
        end
      end else begin
        push = 1'b1;
      end
    end
  end

  assign full    = (cnt_q == CW'(DEPTH));
  assign pop     = (cnt_q != '0) && out_ready_i;
  assign push_ok = push && (!full || pop);

  // One word of credit per tracked op keeps the FIFO from ever being oversubscribed
  always_comb begin
    inflight = '0;
    for (int i = 1; i <= LAT; i++) inflight = inflight + TW'(pipe_vld_q[i]);
  end
  assign issue_ok_o = (TW'(cnt_q) + inflight) < TW'(DEPTH);

  assign out_valid_o = (cnt_q != '0);
  assign out_data_o  = out_valid_o ? mem_q[rd_q] : '0;
  assign out_last_o  = out_valid_o & mem_last_q[rd_q];
  assign fflags_o    = fflags_q;
  assign overflow_o  = ovf_q;
  assign mode_err_o  = merr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pipe_vld_q  <= '0;
      pipe_mode_q <= '0;
      pipe_last_q <= '0;
      mem_q       <= '0;
      mem_last_q  <= '0;
      wr_q        <= '0;
      rd_q        <= '0;
      cnt_q       <= '0;
      pend_vld_q  <= 1'b0;
      pend_q      <= '0;
      tile_act_q  <= 1'b0;
      tile_mode_q <= '0;
      fflags_q    <= '0;
      ovf_q       <= 1'b0;
      merr_q      <= 1'b0;
    end else begin
      pipe_vld_q[1]  <= issue_i;
      pipe_mode_q[1] <= mode_i;
      pipe_last_q[1] <= last_i;
      for (int i = 2; i <= LAT; i++) begin
        pipe_vld_q[i]  <= pipe_vld_q[i-1];
        pipe_mode_q[i] <= pipe_mode_q[i-1];
        pipe_last_q[i] <= pipe_last_q[i-1];
      end

      pend_vld_q <= pend_vld_d;
      pend_q     <= pend_d;

      if (cap) begin
        if (cap_last) begin
          tile_act_q <= 1'b0;
        end else if (!tile_act_q) begin
          tile_act_q  <= 1'b1;
          tile_mode_q <= cap_eff;
        end
      end

      if (push_ok) begin
        mem_q[wr_q]      <= push_data;
        mem_last_q[wr_q] <= cap_last;
        wr_q             <= wr_q + 1'b1;
      end
      if (pop) rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + CW'(push_ok) - CW'(pop);

      if (cap)               fflags_q <= (fflags_clr_i ? 4'b0 : fflags_q) | cap_flags;
      else if (fflags_clr_i) fflags_q <= '0;

      if ((issue_i && !issue_ok_o) || (push && !push_ok)) ovf_q <= 1'b1;
      if (mode_bad) merr_q <= 1'b1;
    end
  end
endmodule

// File: doc/mac_result_collector.md
# mac_result_collector

Drain side of the MAC_FP datapath. Tracks every operation issued to a MAC_FP instance through its fixed pipeline latency, captures the result and fflags when they emerge, and packs FP16 results two per 32-bit word. Writes FP32 and FP16-mix results one per word. Presents packed words to the writeback path through a valid/ready FIFO and provides issue credit, so the operand sequencer never has more results in flight than the FIFO can absorb.

## Interface
Parameters:
- LAT, 2: cycles from `issue_i` to the matching result on `res_i`.
- DEPTH, 4: output FIFO entries; must be a power of two, ≥ 2.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset).
- issue_i  in  1  an operation entered MAC_FP this cycle.
- mode_i  in  2  mode of the issued op: 00 fp16, 01 fp16 mix, 10 fp32, 11 reserved.
- last_i  in  1  issued op is the last of its tile.
- res_i  in  32  MAC_FP OUT[31:0]; valid LAT cycles after the matching issue.
- nv_i, of_i, uf_i, nx_i  in  1 each  MAC_FP exception flags, aligned with res_i.
- issue_ok_o  out  1  upstream may assert issue_i this cycle.
- out_valid_o  out  1  out_data_o/out_last_o hold a word.
- out_ready_i  in  1  consumer accepts the word.
- out_data_o  out  32  packed result word.
- out_last_o  out  1  word closes a tile.
- fflags_o  out  4  sticky {NV,OF,UF,NX}.
- fflags_clr_i  in  1  clear fflags_o.
- overflow_o  out  1  sticky: issue while issue_ok_o=0, or push into a full FIFO.
- mode_err_o  out  1  sticky: reserved mode, or mode change inside a tile.

## Operation
- Tracking pipe: LAT-stage shift register of {valid, mode, last}, loaded from issue_i/mode_i/last_i. Stage LAT output is the "capture" point, which is time-aligned with res_i.
- Tile mode: latched from the first capture after reset or after a last-op. If a later capture in the same tile has a different mode, mode_err_o is set and the tile mode is used. Mode 11 is treated as 10 and sets mode_err_o.
- Packing for tile mode 00:
  - The first capture stores res_i[15:0] in the pending low half.
  - The second capture pushes {res_i[15:0], pending}.
  - A capture with last while a half is pending pushes that pair.
  - A capture with last and no half pending pushes {16'h0, res_i[15:0]}.
  - out_last = last of the pushed capture.
- Tile modes 01 and 10: each capture pushes res_i and its last bit.
- FIFO: DEPTH × {data, last}. Push happens at the capture edge. Pop on out_valid_o & out_ready_i. Push and pop in the same cycle are both performed. A push into a full FIFO is dropped and sets overflow_o.
- Credit: issue_ok_o = (fifo_count + tracked_valid_stages) < DEPTH. This is a conservative bound of one word per in-flight op. An issue_i while issue_ok_o=0 is still tracked and sets overflow_o.
- fflags: on each capture, fflags_o |= {nv,of,uf,nx}. fflags_clr_i zeroes fflags_o. If clear and capture coincide, the result is the capture's flags only.

## Timing
- Reset values:
  - out_valid_o=0, out_data_o=0, out_last_o=0, fflags_o=0, overflow_o=0, mode_err_o=0, issue_ok_o=1.
  - Pipe, pending half, tile mode and FIFO are cleared.
- Reset mid-operation discards all in-flight and buffered results. Results on res_i from pre-reset issues are ignored because the pipe is cleared.
- An op issued at cycle t is captured at edge t+LAT. Its word, if pushed then, appears with out_valid_o=1 from cycle t+LAT+1 when the FIFO was empty.
- out_data_o/out_last_o hold stable while out_valid_o=1 and out_ready_i=0.
- Full FIFO with simultaneous pop and push: both are accepted, and the count is unchanged.
- issue_ok_o is combinational from registered state only; it does not depend on issue_i or out_ready_i in the same cycle.

## Test plan
- Mode 10, LAT=2: issue ops at t=0,1,2 with res_i=32'h3F800000, 40000000, 40400000 at t=2,3,4, last on the third; ready=1 → words appear at t=3,4,5, out_last=1 on 40400000.
- Mode 00: three issues with res_i[15:0]=3C00, 4000, 4200, last on the third → words 32'h40003C00 (last=0), then 32'h00004200 (last=1).
- Back-pressure: DEPTH=4, out_ready_i=0, issue every cycle → issue_ok_o drops after 4 issues; the FIFO fills with 4 words, and no overflow occurs. Raise ready → all 4 drain in order.
- Flags: capture with of_i=1, then one with nx_i=1 → fflags_o=4'b0101. Clear coinciding with a capture carrying nv_i → fflags_o=4'b1000.
- Errors: issue while issue_ok_o=0 → overflow_o=1. A mode 01 op inside a mode-00 tile, or mode 11 → mode_err_o=1.
- Reset (rst=0 for one cycle) with 2 ops in flight and 1 buffered word → out_valid_o=0 after reset, and no words emerge from the pre-reset issues.
